// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flags
// Brief    : Single-clock show-ahead FIFO with a registered level, almost-full
//            and almost-empty thresholds, and sticky overflow/underflow flags.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int LG_DEPTH      = 4,
    parameter int AFULL_THRESH  = (1 << LG_DEPTH) - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [LG_DEPTH:0]     level,
    output logic [LG_DEPTH:0]     space_free,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH    = 1 << LG_DEPTH;
    localparam logic [LG_DEPTH:0] c_DEPTH  = (LG_DEPTH + 1)'(DEPTH);
    localparam logic [LG_DEPTH:0] c_ONE    = (LG_DEPTH + 1)'(1);
    localparam logic [LG_DEPTH:0] c_AFULL  = (LG_DEPTH + 1)'(AFULL_THRESH);
    localparam logic [LG_DEPTH:0] c_AEMPTY = (LG_DEPTH + 1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [LG_DEPTH:0]     r_wrptr;
    logic [LG_DEPTH:0]     r_rdptr;
    logic [LG_DEPTH:0]     r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_wr_drop;
    logic w_rd_drop;
    logic w_mem_we;

    // Pointers carry a wrap bit: equal pointers mean empty, equal low bits
    // with differing wrap bits mean full.
    assign w_empty   = (r_wrptr == r_rdptr);
    assign w_full    = (r_wrptr[LG_DEPTH] != r_rdptr[LG_DEPTH]) &&
                       (r_wrptr[LG_DEPTH-1:0] == r_rdptr[LG_DEPTH-1:0]);
    assign w_rd_ok   = rd_en && !w_empty;
    assign w_wr_ok   = wr_en && (!w_full || w_rd_ok);
    assign w_wr_drop = wr_en && !w_wr_ok;
    assign w_rd_drop = rd_en && !w_rd_ok;
    assign w_mem_we  = rst && !flush && w_wr_ok;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_wrptr <= '0;
            r_rdptr <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wrptr <= r_wrptr + c_ONE;
            end
            if (w_rd_ok) begin
                r_rdptr <= r_rdptr + c_ONE;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + c_ONE;
                2'b01:   r_level <= r_level - c_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Error flags survive a flush; a fresh drop outranks err_clr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!flush) begin
            r_overflow  <= w_wr_drop || (r_overflow && !err_clr);
            r_underflow <= w_rd_drop || (r_underflow && !err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wrptr[LG_DEPTH-1:0]] <= wr_data;
        end
    end

    assign rd_data      = r_mem[r_rdptr[LG_DEPTH-1:0]];
    assign full         = w_full;
    assign empty        = w_empty;
    assign level        = r_level;
    assign space_free   = c_DEPTH - r_level;
    assign almost_full  = (r_level >= c_AFULL);
    assign almost_empty = (r_level <= c_AEMPTY);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO: configurable data width and depth, show-ahead read port, registered occupancy count, programmable almost-full/almost-empty thresholds.
- Requests that would overflow or underflow are dropped internally and recorded in sticky error flags; the FIFO is never corrupted.
- Synchronous flush input.
- Drop-in buffer between byte/word producers and consumers (UART TX/RX paths, stream adapters) where the source cannot guarantee legal requests.

Parameters:
DATA_WIDTH, 8, width of each entry in bits (>=1)
LG_DEPTH, 4, log2 of entry count; DEPTH = 1<<LG_DEPTH (>=1)
AFULL_THRESH, DEPTH-2, almost_full asserted when level >= AFULL_THRESH (1..DEPTH)
AEMPTY_THRESH, 1, almost_empty asserted when level <= AEMPTY_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on next rising edge)
flush  in  1  synchronous clear of contents, pointers and level
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read request (pops head entry)
rd_data  out  DATA_WIDTH  head entry, show-ahead
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AFULL_THRESH
almost_empty  out  1  level <= AEMPTY_THRESH
level  out  LG_DEPTH+1  entries stored
space_free  out  LG_DEPTH+1  DEPTH - level
overflow  out  1  sticky: a write was dropped because the FIFO was full
underflow  out  1  sticky: a read was dropped because the FIFO was empty
err_clr  in  1  clears overflow/underflow

Behaviour:
- Priority per edge: rst==0 > flush > rd/wr operations.
- Reset or flush:
  - rdptr=wrptr=0 and level=0, so empty=1, full=0, space_free=DEPTH, almost_empty=1, almost_full=0.
  - Memory contents are not cleared; rd_data is don't-care while empty.
- Reset only: overflow=underflow=0. Flush leaves the error flags unchanged.
- Pointers are LG_DEPTH+1 bits. The low LG_DEPTH bits address memory; the MSB is the wrap bit. Pointers wrap modulo 2*DEPTH with no special casing.
- Status outputs:
  - level is a register and must always equal wrptr-rdptr (mod 2*DEPTH).
  - All flags and space_free derive combinationally from level/pointers, so they reflect an accepted op on the cycle after the edge.
- Request acceptance:
  - Write accepted (wr_ok) iff wr_en && (!full || rd_ok).
  - Read accepted (rd_ok) iff rd_en && !empty.
- Simultaneous requests:
  - rd_en && wr_en while full: both accepted; level stays DEPTH.
  - rd_en && wr_en while empty: write accepted, read dropped (underflow set); level becomes 1.
  - rd_ok && wr_ok otherwise: both pointers advance; level unchanged.
- Accepted ops:
  - wr_ok writes mem[wrptr] and increments wrptr.
  - rd_ok increments rdptr.
  - level += wr_ok - rd_ok.
- rd_data = mem[rdptr] combinationally.
  - Valid whenever empty==0; zero read latency (data present before rd_en).
  - A write into an empty FIFO appears on rd_data the cycle after the write edge.
- Dropped requests:
  - wr_en && !wr_ok sets overflow; rd_en && !rd_ok sets underflow.
  - Pointers and level do not change.
- err_clr clears both flags. A new error event in the same cycle wins (flag stays 1).
- flush with rd_en/wr_en in the same cycle: the requests are ignored and set no error flags.
- Threshold flags follow level exactly, with no hysteresis.

Test Plan:
- Reset: hold rst=0 for 2 cycles with wr_en=1 -> empty=1, full=0, level=0, space_free=16, almost_empty=1, overflow=0, underflow=0.
- Fill (defaults): 16 writes of 0x10..0x1F.
  - almost_full rises after the 14th write; full=1 after the 16th; level=16, space_free=0.
  - A 17th write sets overflow=1; level stays 16 and rd_data stays 0x10.
- Drain with wrap: after a fill, 8 reads, 8 writes (0xA0..0xA7), then 16 reads.
  - rd_data sequence is 0x18..0x1F then 0xA0..0xA7.
  - empty=1 after the last read; almost_empty rises when level reaches 1.
- Simultaneous requests:
  - rd_en=wr_en=1 while full: level stays 16, head advances by one, overflow stays 0.
  - rd_en=wr_en=1 while empty (data 0x55): level=1, rd_data=0x55, underflow=1.
- Flush and err_clr:
  - With level=5 and overflow=1, assert flush with wr_en=1 -> level=0, empty=1, overflow still 1.
  - Then err_clr -> overflow=0.
  - Mid-stream rst=0 at level=9 -> all outputs return to reset values next cycle.
- Parameter sweep: DATA_WIDTH=32, LG_DEPTH=1, AFULL_THRESH=2, AEMPTY_THRESH=0 -> full after 2 writes; almost_empty only at level 0; random rd/wr for 10k cycles matches a reference queue model.
